// File: rtl/sfu_pkg.sv
// Shared definitions for the sequential special-function unit:
// default widths, operation codes and FSM state encoding.
package sfu_pkg;

    localparam int unsigned SFU_W   = 16;
    localparam int unsigned SFU_SHW = 4;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_BIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/sfu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per step.
// load performs the first step directly from the operands, so a full
// W-bit product needs load followed by W-1 steps. Only the low W bits
// of the product are kept.
module sfu_mul_iter
    import sfu_pkg::*;
#(
    parameter int W = SFU_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product
);

    logic [W-1:0] acc_q,    acc_d;
    logic [W-1:0] mcand_q,  mcand_d;
    logic [W-1:0] mplier_q, mplier_d;

    // Next accumulator / shifted operands for a load or a single step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Multiplier iteration registers.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of statement order.
        if (RST) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/sfu_seq.sv
// Sequential special-function unit: add-with-carry and bit set/clear/test
// complete in one cycle; multiply (W cycles busy) and arithmetic shift
// right (one cycle per shift position) iterate under a small FSM.
module sfu_seq
    import sfu_pkg::*;
#(
    parameter int W   = SFU_W,
    parameter int SHW = SFU_SHW
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Start,
    input  logic         SFU_sel,
    input  logic [1:0]   S,
    input  logic         Set,
    input  logic         Tst,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic [W-1:0] F,
    output logic         V,
    output logic         C,
    output logic         N,
    output logic         Z,
    output logic         Busy,
    output logic         Done
);

    state_e         state_q, state_d;
    logic [W-1:0]   f_q, f_d;
    logic           v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d;
    logic           done_q, done_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [SHW-1:0] cnt_q, cnt_d;

    logic           accept;
    logic [SHW-1:0] k;
    logic [W:0]     add_sum;
    logic [W-1:0]   bit_mask;
    logic [W-1:0]   asr_next;
    logic           bit_test;
    logic           mul_load, mul_step;
    logic [W-1:0]   mul_product;

    assign accept   = (state_q == ST_IDLE) && Start && SFU_sel;
    assign k        = B[SHW-1:0];
    assign add_sum  = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, C_in};
    assign bit_mask = {{(W-1){1'b0}}, 1'b1} << k;
    assign asr_next = {sh_q[W-1], sh_q[W-1:1]};

    sfu_mul_iter #(.W(W)) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .load    (mul_load),
        .step    (mul_step),
        .a       (A),
        .b       (B),
        .product (mul_product)
    );

    // FSM state register; reset wins over any pending request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only multiply and non-zero shifts leave IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (S == OP_MUL) begin
                        state_d = ST_MUL;
                    end else if (S == OP_ASR && k != '0) begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_MUL:   if (cnt_q == '0)        state_d = ST_IDLE;
            ST_SHIFT: if (cnt_q == SHW'(1))   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and registered result/flag outputs.
    always_comb begin
        Busy = (state_q != ST_IDLE);
        Done = done_q;
        F    = f_q;
        V    = v_q;
        C    = c_q;
        N    = n_q;
        Z    = z_q;
    end

    // Datapath: result, flags and iteration registers for each operation.
    always_comb begin
        f_d      = f_q;
        v_d      = v_q;
        c_d      = c_q;
        n_d      = n_q;
        z_d      = z_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        bit_test = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (S)
                        OP_ADD: begin
                            f_d    = add_sum[W-1:0];
                            c_d    = add_sum[W];
                            v_d    = (A[W-1] == B[W-1]) && (add_sum[W-1] != A[W-1]);
                            done_d = 1'b1;
                        end
                        OP_BIT: begin
                            if (Set) begin
                                f_d = A | bit_mask;
                            end else if (Tst) begin
                                f_d      = A;
                                bit_test = 1'b1;
                            end else begin
                                f_d = A & ~bit_mask;
                            end
                            c_d    = 1'b0;
                            v_d    = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_ASR: begin
                            if (k == '0) begin
                                f_d    = A;
                                c_d    = 1'b0;
                                v_d    = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                sh_d  = A;
                                cnt_d = k;
                            end
                        end
                        default: begin
                            // Multiply: the load performs the first of W steps.
                            mul_load = 1'b1;
                            cnt_d    = SHW'(W - 1);
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q != '0) begin
                    mul_step = 1'b1;
                    cnt_d    = cnt_q - SHW'(1);
                end else begin
                    f_d    = mul_product;
                    c_d    = 1'b0;
                    v_d    = 1'b0;
                    done_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                // The final shift goes straight to F so Done lands n+1 cycles after acceptance.
                if (cnt_q == SHW'(1)) begin
                    f_d    = asr_next;
                    c_d    = sh_q[0];
                    v_d    = 1'b0;
                    done_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    sh_d  = asr_next;
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            default: ;
        endcase
        if (done_d) begin
            n_d = f_d[W-1];
            z_d = bit_test ? ~A[k] : (f_d == '0);
        end
    end

    // Result, flag and iteration registers.
    always_ff @(posedge CLK) begin
        // NOTE: iteration registers are reset along with the outputs so an abandoned operation leaves no residue.
        if (RST) begin
            f_q    <= '0;
            v_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            done_q <= 1'b0;
            sh_q   <= '0;
            cnt_q  <= '0;
        end else begin
            f_q    <= f_d;
            v_q    <= v_d;
            c_q    <= c_d;
            n_q    <= n_d;
            z_q    <= z_d;
            done_q <= done_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sfu_seq.sv
// Self-checking bench for sfu_seq: directed examples, control cases and
// randomized operations compared against an arithmetic reference model.
module tb_sfu_seq;

    localparam int W = 16;

    logic         CLK, RST, Start, SFU_sel, Set, Tst, C_in;
    logic [1:0]   S;
    logic [W-1:0] A, B, F;
    logic         V, C, N, Z, Busy, Done;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] prev_f = '0;

    sfu_seq dut (
        .CLK(CLK), .RST(RST), .Start(Start), .SFU_sel(SFU_sel), .S(S),
        .Set(Set), .Tst(Tst), .A(A), .B(B), .C_in(C_in),
        .F(F), .V(V), .C(C), .N(N), .Z(Z), .Busy(Busy), .Done(Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: result, flags and cycles from acceptance to Done.
    function automatic void model(input logic [1:0] s, input logic set, input logic tst,
                                  input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                  output logic [W-1:0] f, output logic v, output logic c,
                                  output logic n, output logic z, output int lat);
        int       sh;
        int       sint;
        logic [31:0] prod;
        logic [W:0]  sum;
        logic        ztest;
        sh    = int'(b[3:0]);
        v     = 1'b0;
        c     = 1'b0;
        lat   = 1;
        ztest = 1'b0;
        case (s)
            2'b00: begin
                prod = 32'(a) * 32'(b);
                f    = prod[W-1:0];
                lat  = W + 1;
            end
            2'b01: begin
                sum  = 17'(a) + 17'(b) + 17'(cin);
                f    = sum[W-1:0];
                c    = sum[W];
                sint = int'($signed(a)) + int'($signed(b)) + int'(cin);
                v    = (sint > 32767) || (sint < -32768);
            end
            2'b10: begin
                f   = W'($signed(a) >>> sh);
                c   = (sh == 0) ? 1'b0 : a[sh-1];
                lat = sh + 1;
            end
            default: begin
                if (set)      f = a | (16'(1) << sh);
                else if (tst) begin f = a; ztest = 1'b1; end
                else          f = a & ~(16'(1) << sh);
            end
        endcase
        n = f[W-1];
        z = ztest ? ~a[sh] : (f == '0);
    endfunction

    // Issue one operation on the current cycle and follow it to Done.
    // mode 0: quiet, 1: random noise on inputs while busy, 2: Start held high while busy.
    task automatic run_op(input logic [1:0] s, input logic set, input logic tst,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int mode);
        logic [W-1:0] ef;
        logic ev, ec, en, ez;
        int lat;
        model(s, set, tst, a, b, cin, ef, ev, ec, en, ez, lat);
        Start = 1'b1; SFU_sel = 1'b1; S = s; Set = set; Tst = tst;
        A = a; B = b; C_in = cin;
        for (int i = 1; i <= lat; i++) begin
            @(negedge CLK);
            if (i < lat) begin
                check("busy", 32'({Busy, Done, F}), 32'({1'b1, 1'b0, prev_f}));
                Start   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
                SFU_sel = (mode == 2) ? 1'b1 : 1'($urandom);
                S       = 2'($urandom);
                Set     = 1'($urandom);
                Tst     = 1'($urandom);
                A       = W'($urandom);
                B       = W'($urandom);
                C_in    = 1'($urandom);
            end else begin
                check("done", 32'({Busy, Done}), 32'(2'b01));
                check("result", 32'(F), 32'(ef));
                check("flags", 32'({V, C, N, Z}), 32'({ev, ec, en, ez}));
                Start = 1'b0;
            end
        end
        prev_f = ef;
    endtask

    initial begin
        bit saw;
        RST = 1'b1; Start = 1'b0; SFU_sel = 1'b0; S = 2'b00; Set = 1'b0; Tst = 1'b0;
        A = '0; B = '0; C_in = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("reset_state", 32'({Busy, Done, F, V, C, N, Z}), 32'(0));

        // Directed examples
        run_op(2'b01, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        check("add_example", 32'({F, V, N, C, Z}), 32'({16'h8000, 4'b1100}));
        run_op(2'b00, 1'b0, 1'b0, 16'h0012, 16'h0034, 1'b0, 2);
        check("mul_example", 32'(F), 32'(16'h03A8));
        run_op(2'b10, 1'b0, 1'b0, 16'h8004, 16'h0003, 1'b0, 1);
        check("asr_example", 32'({F, C, N}), 32'({16'hF000, 2'b11}));
        run_op(2'b11, 1'b1, 1'b0, 16'h0000, 16'h0005, 1'b0, 0);
        check("bit_set", 32'(F), 32'(16'h0020));
        run_op(2'b11, 1'b0, 1'b0, 16'hFFFF, 16'h000F, 1'b0, 0);
        check("bit_clr", 32'(F), 32'(16'h7FFF));
        run_op(2'b11, 1'b0, 1'b1, 16'h0010, 16'h0004, 1'b0, 0);
        check("bit_tst", 32'({F, Z}), 32'({16'h0010, 1'b0}));
        run_op(2'b10, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 0);
        run_op(2'b10, 1'b0, 1'b0, 16'h8001, 16'h000F, 1'b0, 1);

        // Start without SFU_sel is ignored
        Start = 1'b1; SFU_sel = 1'b0; S = 2'b01; A = 16'h0001; B = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("no_sel", 32'({Busy, Done, F}), 32'({1'b0, 1'b0, prev_f}));
        end
        Start = 1'b0;

        // Reset at cycle 8 of a multiply abandons it
        Start = 1'b1; SFU_sel = 1'b1; S = 2'b00; A = 16'h0005; B = 16'h0007;
        @(negedge CLK);
        Start = 1'b0;
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_abandon", 32'({Busy, Done, F, V, C, N, Z}), 32'(0));
        RST = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            if (Done || Busy) saw = 1'b1;
        end
        check("no_late_done", 32'(saw), 32'(0));

        // Reset takes priority over a simultaneous request
        RST = 1'b1; Start = 1'b1; SFU_sel = 1'b1; S = 2'b01; A = 16'h0003; B = 16'h0004;
        @(negedge CLK);
        check("rst_priority", 32'({Busy, Done, F}), 32'(0));
        RST = 1'b0; Start = 1'b0;
        @(negedge CLK);
        prev_f = '0;

        // Randomized operations, issued back-to-back
        for (int i = 0; i < 150; i++) begin
            run_op(2'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
                   W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sfu_seq.md
SFU_SEQ -- requirements
Module: sfu_seq

Interface
REQ-001 SHALL have parameter W, default 16: datapath width in bits.
REQ-002 SHALL have parameter SHW, default 4: width of the shift/bit-index field, equal to log2(W).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Start  input  1  operation request, sampled on the rising edge.
REQ-006 SHALL have port SFU_sel  input  1  special-function select from the function decoder.
REQ-007 SHALL have port S  input  2  operation code: 00 multiply, 01 add-with-carry, 10 arithmetic shift right, 11 bit operation.
REQ-008 SHALL have port Set  input  1  when S=11, selects bit-set over bit-clear.
REQ-009 SHALL have port Tst  input  1  FS[1]; when S=11 and Set=0, selects bit-test over bit-clear.
REQ-010 SHALL have ports A and B  input  W  operands.
REQ-011 SHALL have port C_in  input  1  carry into add-with-carry.
REQ-012 SHALL have port F  output  W  registered result.
REQ-013 SHALL have ports V, C, N, Z  output  1 each  registered status flags.
REQ-014 SHALL have port Busy  output  1  high while a multi-cycle operation is in progress.
REQ-015 SHALL have port Done  output  1  one-cycle pulse marking result valid.

Function
REQ-016 SHALL use an FSM with states IDLE, MUL, SHIFT.
REQ-017 SHALL accept an operation only in IDLE when Start=1 and SFU_sel=1; Start=1 with SFU_sel=0 SHALL be ignored.
REQ-018 SHALL ignore Start while Busy=1.
REQ-019 SHALL latch S, Set, Tst, A, B and C_in at acceptance, so input changes after acceptance have no effect.
REQ-020 Add (S=01) SHALL produce F = A+B+C_in, C = carry-out, V = signed overflow, with Done in the cycle after acceptance.
REQ-021 Bit ops (S=11) SHALL use bit index k = B[SHW-1:0], with Done in the cycle after acceptance, as follows:
  - Set=1 (set): F = A with bit k forced to 1.
  - Set=0, Tst=0 (clear): F = A with bit k forced to 0.
  - Tst=1 (test): F = A unchanged, Z = ~A[k].
  - C=0 and V=0 for all bit ops.
REQ-022 Multiply (S=00) SHALL be iterative shift-add, 1 bit per cycle, as follows:
  - Latency: Busy for W cycles; Done asserted W+1 cycles after acceptance.
  - F = low W bits of the unsigned product.
  - C=0, V=0.
REQ-023 ASR (S=10) SHALL shift by n = B[SHW-1:0], 1 bit per cycle, sign-preserving, as follows:
  - Latency: Done n+1 cycles after acceptance; Busy high for n cycles.
  - n=0: behaves as a single-cycle op with F=A and C=0.
  - C = last bit shifted out; V=0.
REQ-024 SHALL set N = F[W-1], and Z = (F==0) for every op except bit-test.
REQ-025 SHALL hold F and flags stable from Done until the next Done.
REQ-026 SHALL keep Done high for exactly one cycle per accepted operation.
REQ-027 SHALL be able to accept a new Start in the same cycle that Done is high.

Reset
REQ-028 RST=1 SHALL, at the next rising edge, return the FSM to IDLE and clear F, V, C, N, Z, Busy, Done and all internal iteration registers to 0.
REQ-029 RST SHALL take priority over Start.
REQ-030 An operation in progress when RST asserts SHALL be abandoned and SHALL produce no Done.

Structure
REQ-031 Package sfu_pkg SHALL hold the FSM state encoding, the S operation-code constants and the default W/SHW.
REQ-032 The iterative multiplier datapath SHALL be one sub-module named sfu_mul_iter, with load/step/product ports.
REQ-033 Shift and bit-op logic SHALL remain inside sfu_seq.

Verification
REQ-034 Add: A=0x7FFF, B=0x0001, C_in=0 -> one cycle after acceptance, Done=1, F=0x8000, V=1, N=1, C=0, Z=0.
REQ-035 Multiply: A=0x0012, B=0x0034 -> Busy high for 16 cycles, then Done at cycle 17 with F=0x03A8, Z=0.
REQ-036 ASR: A=0x8004, B=3 -> Done at cycle 4 with F=0xF000, C=1, N=1.
REQ-037 Bit ops, in sequence:
  - Set: A=0x0000, B=5 -> F=0x0020.
  - Clear: A=0xFFFF, B=15 -> F=0x7FFF.
  - Test: A=0x0010, B=4 -> Z=0, F=0x0010.
REQ-038 Control: with SFU_sel=0 and Start=1, no Done; Start during multiply is ignored; RST at cycle 8 of a multiply gives Busy=0, Done=0, F=0 on the next cycle and no later Done.
